// File: rtl/prism_in_filter.sv
// prism_in_filter
//   Input conditioning ahead of the PRISM FSM input bus. Each raw pin is
//   passed through a two-flop synchroniser and then a per-bit glitch filter.
//   The filter accepts a new level only after it has disagreed with the
//   current filtered level for filt_len+1 consecutive evaluations. The
//   filtered levels also produce one-cycle rise/fall pulses, sticky
//   per-bit edge flags and a registered aggregate interrupt.
//
//   Optional build macro: PRISM_IN_FILTER_PRESCALE_EN
//     Adds filt_prescale and a free-running divider, so the filter
//     advances only once every filt_prescale+1 clocks.
//
// Ports
//   clk            system clock
//   rst            asynchronous active-high reset
//   pin_in         raw, unsynchronised pin levels
//   filt_len       filter length N (0 = no filtering)
//   filt_prescale  filter tick divider (only with the prescale macro)
//   rise_en        per-bit enable: rising edge sets the sticky flag
//   fall_en        per-bit enable: falling edge sets the sticky flag
//   flag_clr       per-bit one-cycle clear of the sticky flags
//   in_filt        filtered levels
//   rise_pulse     one-cycle pulse after in_filt goes 0->1
//   fall_pulse     one-cycle pulse after in_filt goes 1->0
//   edge_flags     sticky edge flags
//   irq            registered OR of edge_flags

module prism_in_filter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pin_in,
  input  logic [CNT_W-1:0] filt_len,
`ifdef PRISM_IN_FILTER_PRESCALE_EN
  input  logic [7:0]       filt_prescale,
`endif
  input  logic [WIDTH-1:0] rise_en,
  input  logic [WIDTH-1:0] fall_en,
  input  logic [WIDTH-1:0] flag_clr,
  output logic [WIDTH-1:0] in_filt,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic [WIDTH-1:0] edge_flags,
  output logic             irq
);

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0] in_filt_q, in_filt_d;
  logic [WIDTH-1:0] in_filt_dly_q, in_filt_dly_d;
  logic [WIDTH-1:0] rise_pulse_q, rise_pulse_d;
  logic [WIDTH-1:0] fall_pulse_q, fall_pulse_d;
  logic [WIDTH-1:0] edge_flags_q, edge_flags_d;
  logic             irq_q, irq_d;
  logic             tick;

`ifdef PRISM_IN_FILTER_PRESCALE_EN
  logic [7:0] div_q, div_d;

  // >= rather than == so that lowering filt_prescale below the current
  // divider value restarts the period instead of waiting for a wrap.
  always_comb begin
    tick  = (div_q >= filt_prescale);
    div_d = tick ? 8'd0 : div_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) div_q <= 8'd0;
    else     div_q <= div_d;
  end
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    sync1_d = pin_in;
    sync2_d = sync1_q;
  end

  // A matching sample always clears the count, even off-tick; a mismatch
  // only advances on tick. The >= compare fires before the count can wrap
  // and also makes a shortened filt_len take effect at once.
  always_comb begin
    in_filt_d = in_filt_q;
    cnt_d     = cnt_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync2_q[i] == in_filt_q[i]) begin
        cnt_d[i] = '0;
      end else if (tick) begin
        if (cnt_q[i] >= filt_len) begin
          in_filt_d[i] = sync2_q[i];
          cnt_d[i]     = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Set terms win over a simultaneous clear.
  always_comb begin
    in_filt_dly_d = in_filt_q;
    rise_pulse_d  = in_filt_q & ~in_filt_dly_q;
    fall_pulse_d  = ~in_filt_q & in_filt_dly_q;
    edge_flags_d  = (edge_flags_q & ~flag_clr)
                  | (rise_pulse_q & rise_en)
                  | (fall_pulse_q & fall_en);
    irq_d         = |edge_flags_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      in_filt_q     <= '0;
      in_filt_dly_q <= '0;
      rise_pulse_q  <= '0;
      fall_pulse_q  <= '0;
      edge_flags_q  <= '0;
      irq_q         <= 1'b0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      cnt_q         <= cnt_d;
      in_filt_q     <= in_filt_d;
      in_filt_dly_q <= in_filt_dly_d;
      rise_pulse_q  <= rise_pulse_d;
      fall_pulse_q  <= fall_pulse_d;
      edge_flags_q  <= edge_flags_d;
      irq_q         <= irq_d;
    end
  end

  assign in_filt    = in_filt_q;
  assign rise_pulse = rise_pulse_q;
  assign fall_pulse = fall_pulse_q;
  assign edge_flags = edge_flags_q;
  assign irq        = irq_q;

endmodule
